// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared widths, divider FSM encoding and divide-by-zero constant
package arith_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/ripple_adder8.sv
// rtl/ripple_adder8.sv - ripple-carry adder, 8 bits by default
module ripple_adder8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar k = 0; k < W; k++) begin : g_fa
    assign o_sum[k]  = i_a[k] ^ i_b[k] ^ w_c[k];
    assign w_c[k+1]  = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
  end

  assign o_cout = w_c[W];

endmodule

// File: rtl/divider_int8_seq.sv
// rtl/divider_int8_seq.sv - sequential restoring unsigned divider, one quotient bit per clock
module divider_int8_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r,
  output logic             o_div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_rem, r_dvd, r_quo, r_q, r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done, r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sum, w_rem_nxt;
  logic             w_cout, w_nb;

  // The stored remainder is always below b, so only the shifted trial value needs the extra bit.
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_nb      = w_shift[WIDTH] | w_cout;
  assign w_rem_nxt = w_nb ? w_sum : w_shift[WIDTH-1:0];

  ripple_adder8 #(.W(WIDTH)) u_sub (
    .i_a    (w_shift[WIDTH-1:0]),
    .i_b    (~r_b),
    .i_cin  (1'b1),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = (i_b == '0) ? ST_FIN : ST_RUN;
      ST_RUN:  if (r_cnt == '0) w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_rem  <= '0;
      r_dvd  <= '0;
      r_quo  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_q    <= '0;
            r_r    <= '0;
            r_dbz  <= 1'b0;
            r_rem  <= '0;
            r_dvd  <= i_a;
            r_quo  <= '0;
            r_cnt  <= CW'(WIDTH - 1);
            r_busy <= 1'b1;
          end
        end
        ST_RUN: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_quo <= {r_quo[WIDTH-2:0], w_nb};
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        ST_FIN: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_b == '0) begin
            r_q   <= DBZ_QUOTIENT;
            r_r   <= r_a;
            r_dbz <= 1'b1;
          end else begin
            r_q <= r_quo;
            r_r <= r_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_q           = r_q;
  assign o_r           = r_r;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_int8_seq.sv
// tb/tb_divider_int8_seq.sv - scoreboard bench for the sequential int8 divider
module tb_divider_int8_seq;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, dz;
  logic [7:0] q, r;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_start = 0;
  int   n_done = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  divider_int8_seq dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_a           (a),
    .i_b           (b),
    .o_busy        (busy),
    .o_done        (done),
    .o_q           (q),
    .o_r           (r),
    .o_div_by_zero (dz)
  );

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    if (y == 8'd0) begin
      e.q = 8'hFF; e.r = x; e.dz = 1'b1;
    end else begin
      e.q = x / y; e.r = x % y; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor: every done pulse pops and checks one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty: done pulse with q=%0d r=%0d dz=%0b, no result expected", q, r, dz);
      end else begin
        e = sb.pop_front();
        if ({q, r, dz} !== {e.q, e.r, e.dz}) begin
          n_err++;
          $display("FAIL result: got q=%0d r=%0d dz=%0b, want q=%0d r=%0d dz=%0b", q, r, dz, e.q, e.r, e.dz);
        end
      end
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_at_done: got %0b want 0", busy);
      end
    end
  end

  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #1;
    sb.push_back(model(x, y));
    n_start++;
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom_range(0, 255); b = $urandom_range(0, 255);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, q, r, dz} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b q=%0d r=%0d dz=%0b want all 0", busy, done, q, r, dz);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int nb = 0, nd = 0, lat = -1;
    issue(8'd200, 8'd7);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin nd++; lat = i; end
    end
    n_cmp++;
    if (nb !== 9) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 9", nb); end
    n_cmp++;
    if (nd !== 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", nd); end
    n_cmp++;
    if (lat !== 9) begin n_err++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_cmp++;
    if ({q, r, dz} !== {8'd28, 8'd4, 1'b0}) begin
      n_err++;
      $display("FAIL basic_hold: got q=%0d r=%0d dz=%0b want q=28 r=4 dz=0", q, r, dz);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(8'd255, 8'd1);
    wait_done(lat);
    n_cmp++;
    if (lat !== 9) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 9", lat); end
    sb.push_back(model(8'd5, 8'd9));
    n_start++;
    start = 1'b1; a = 8'd5; b = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_accept: got done=%0b busy=%0b want done=0 busy=1", done, busy);
    end
    wait_done(lat);
    n_cmp++;
    if (lat !== 8) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 8", lat); end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL b2b_pulse_width: got done=%0b want 0", done); end
  endtask

  task automatic test_div_zero();
    int lat;
    issue(8'd100, 8'd0);
    wait_done(lat);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    issue(8'd9, 8'd3);
    @(negedge clk);
    n_cmp++;
    if ({q, r, dz} !== 17'd0) begin
      n_err++;
      $display("FAIL dbz_cleared_on_start: got q=%0d r=%0d dz=%0b want 0", q, r, dz);
    end
    wait_done(lat);
    n_cmp++;
    if (lat !== 8) begin n_err++; $display("FAIL dbz_next_latency: got %0d want 8", lat); end
  endtask

  task automatic test_ignore_busy();
    int nd = 0;
    issue(8'd50, 8'd5);
    start = 1'b1; a = 8'd1; b = 8'd1;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    n_cmp++;
    if (nd !== 1) begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    n_cmp++;
    if ({q, r} !== {8'd10, 8'd0}) begin
      n_err++;
      $display("FAIL ignore_result: got q=%0d r=%0d want q=10 r=0", q, r);
    end
  endtask

  task automatic test_reset_mid();
    int nd = 0, lat;
    issue(8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, q, r, dz} !== 19'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: got busy=%0b done=%0b q=%0d r=%0d dz=%0b want all 0", busy, done, q, r, dz);
    end
    sb.delete();
    n_start--;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    n_cmp++;
    if (nd !== 0) begin n_err++; $display("FAIL midreset_no_done: got %0d active cycles want 0", nd); end
    issue(8'd0, 8'd13);
    wait_done(lat);
    n_cmp++;
    if (lat !== 9) begin n_err++; $display("FAIL midreset_next_latency: got %0d want 9", lat); end
  endtask

  task automatic test_sweep();
    int lat;
    logic [7:0] x, y;
    for (int k = 0; k < 400; k++) begin
      x = $urandom_range(0, 255);
      y = (k % 17 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (k == 1) begin x = 8'd255; y = 8'd255; end
      if (k == 2) begin x = 8'd0;   y = 8'd255; end
      if (k == 3) begin x = 8'd254; y = 8'd255; end
      issue(x, y);
      wait_done(lat);
      n_cmp++;
      if (lat < 0) begin
        n_err++;
        $display("FAIL sweep_timeout: a=%0d b=%0d no done within 40 cycles", x, y);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (n_done !== n_start) begin
      n_err++;
      $display("FAIL done_count: got %0d dones want %0d starts", n_done, n_start);
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_busy();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divider_int8_seq.md
Name: divider_int8_seq

Overview:
Sequential unsigned integer divider. It is the inverse operation of the team's combinational int8 multiplier.
Computes quotient and remainder of a / b using restoring division, one quotient bit per clock.
Sits beside the multiplier in the arithmetic playground and reuses the existing 8-bit ripple adder as its subtractor.
Start/done handshake lets a controller or testbench issue back-to-back operations.

Parameters:
WIDTH, 8, operand/result width in bits. Iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a division; sampled only when busy=0
a  input  WIDTH  dividend; captured when start is accepted
b  input  WIDTH  divisor; captured when start is accepted
busy  output  1  operation in progress; start is ignored while high
done  output  1  one-cycle pulse when q/r/div_by_zero are valid
q  output  WIDTH  quotient; held until the next accepted start
r  output  WIDTH  remainder; held until the next accepted start
div_by_zero  output  1  b was 0 for the last completed operation; held with q/r

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low asynchronously forces state=IDLE, busy=0, done=0, q=0, r=0, div_by_zero=0, internal regs=0.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On an edge with start=1, latch a and b and clear q/r/div_by_zero.
  - If b!=0: go to RUN. Set partial remainder=0, dividend shift reg=a, count=WIDTH-1, busy=1.
  - If b==0: go to FIN with busy=1.
- RUN, each edge:
  - Shift the WIDTH+1-bit partial remainder left and bring in the dividend MSB.
  - Trial-subtract b, computed as rem + ~b + 1 through the ripple adder.
  - If the subtraction does not borrow: keep the difference and shift 1 into the quotient. Otherwise restore and shift 0.
  - When count==0, go to FIN; otherwise decrement count.
- FIN, one edge:
  - Normal operation: register q and r, and pulse done=1 for exactly one cycle.
  - b==0 case: q = all ones (8'hFF), r = captured a, div_by_zero=1, done=1.
  - busy=0 in the same cycle done is high. Return to IDLE.
- Latency, with the start edge as E0:
  - b!=0: iterations on E1..E8, FIN registers on E9, so done is high in the cycle after E9. busy is high for 9 cycles.
  - b==0: done is high after E1.
- start while busy=1 is ignored with no side effects. Inputs a/b may change freely after acceptance.
- start in the cycle done is high is accepted, since busy=0. Back-to-back throughput is 1 op per WIDTH+2 cycles.
- Outputs q/r/div_by_zero stay stable from done until the next accepted start.
- Reset asserted mid-operation aborts the operation: no done pulse, all outputs 0.
- Width rule: the partial remainder is WIDTH+1 bits so the subtractor carry-out marks no-borrow. Results are always exact; there is no overflow output.

Decomposition:
- Shared package (arith_pkg): WIDTH default, FSM state encoding (IDLE/RUN/FIN), and the divide-by-zero quotient constant (all ones).
- Reuse the existing ripple_adder8 for the trial subtraction (b inverted, carry-in=1). Its carry-out is the no-borrow flag.
- Everything else (FSM, counter, shift regs) stays in this module.

Test Plan:
- a=200, b=7, start one cycle -> busy high 9 cycles; done pulses once; q=28, r=4, div_by_zero=0.
- a=255, b=1 then a=5, b=9 issued back-to-back, second start in the done cycle -> q=255, r=0; then q=0, r=5. Each done is a single-cycle pulse.
- a=100, b=0 -> done one cycle after start; q=255, r=100, div_by_zero=1. The next op a=9, b=3 clears it: q=3, r=0, div_by_zero=0.
- a=50, b=5 started, then start=1 with a=1, b=1 held for 4 cycles mid-op -> ignored; result q=10, r=0.
- Reset pulse 4 cycles into a=200, b=7 -> outputs immediately 0, no done. A new op a=0, b=13 then gives q=0, r=0.
- Random sweep of all a, b in 0..255 against the reference model a/b, a%b, with b=0 handled as above -> zero mismatches; done count equals start count.
